// File: rtl/ddot_chunk_sched_if.sv
// Bundle of command, buffer-read, dot-product and result signals around ddot_chunk_sched.
// master is the scheduler side; slave is the host/buffer/datapath side.
interface ddot_chunk_sched_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             start;
    logic [CNT_W-1:0] num_chunks;
    logic             busy;
    logic             done;
    logic             err;
    logic             rd_en;
    logic [CNT_W-1:0] rd_addr;
    logic [255:0]     rd_x;
    logic [255:0]     rd_y;
    logic             dd_ready;
    logic [255:0]     dd_x;
    logic [255:0]     dd_y;
    logic             dd_vld;
    logic [31:0]      dd_z;
    logic             res_vld;
    logic [CNT_W-1:0] res_idx;
    logic [31:0]      res_z;

    modport master (
        input  start, num_chunks, rd_x, rd_y, dd_vld, dd_z,
        output busy, done, err, rd_en, rd_addr, dd_ready, dd_x, dd_y, res_vld, res_idx, res_z
    );

    modport slave (
        output start, num_chunks, rd_x, rd_y, dd_vld, dd_z,
        input  busy, done, err, rd_en, rd_addr, dd_ready, dd_x, dd_y, res_vld, res_idx, res_z
    );
endinterface

// File: rtl/ddot_chunk_sched.sv
// Issues 8-lane chunk reads to a dual-operand buffer, pulses basic_ddot once per chunk and
// returns each partial result tagged with its chunk index, limiting chunks in flight by credit.
module ddot_chunk_sched #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MAX_OUT = 4
) (
    input logic                clk,
    input logic                rst,
    ddot_chunk_sched_if.master bus_io
);
    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

    localparam logic [CNT_W:0] MaxOut = (CNT_W + 1)'(MAX_OUT);

    state_e           state_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] iss_q;
    logic [CNT_W-1:0] col_q;
    logic [CNT_W:0]   out_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             rd_en_q;
    logic [CNT_W-1:0] rd_addr_q;
    logic             dd_ready_q;
    logic             res_vld_q;
    logic [CNT_W-1:0] res_idx_q;
    logic [31:0]      res_z_q;

    logic issue;
    logic collect;

    // Credit is taken when the read is decided, so out_q already covers the read in flight.
    always_comb begin
        issue   = (state_q == StIssue) && (iss_q < n_q) && (out_q < MaxOut);
        collect = bus_io.dd_vld && (out_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            iss_q      <= '0;
            col_q      <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            dd_ready_q <= 1'b0;
            res_vld_q  <= 1'b0;
            res_idx_q  <= '0;
            res_z_q    <= '0;
        end else begin
            rd_en_q    <= issue;
            dd_ready_q <= rd_en_q;
            res_vld_q  <= collect;
            done_q     <= 1'b0;

            if (issue) begin
                rd_addr_q <= iss_q;
                iss_q     <= iss_q + 1'b1;
            end

            if (issue && !collect) begin
                out_q <= out_q + 1'b1;
            end else if (!issue && collect) begin
                out_q <= out_q - 1'b1;
            end

            if (collect) begin
                res_z_q   <= bus_io.dd_z;
                res_idx_q <= col_q;
                col_q     <= col_q + 1'b1;
            end else if (bus_io.dd_vld) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        n_q    <= bus_io.num_chunks;
                        iss_q  <= '0;
                        col_q  <= '0;
                        out_q  <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus_io.num_chunks == '0) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (iss_q == n_q) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (col_q == n_q) begin
                        state_q <= StFin;
                        done_q  <= 1'b1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.busy     = busy_q;
    assign bus_io.done     = done_q;
    assign bus_io.err      = err_q;
    assign bus_io.rd_en    = rd_en_q;
    assign bus_io.rd_addr  = rd_addr_q;
    assign bus_io.dd_ready = dd_ready_q;
    assign bus_io.dd_x     = bus_io.rd_x;
    assign bus_io.dd_y     = bus_io.rd_y;
    assign bus_io.res_vld  = res_vld_q;
    assign bus_io.res_idx  = res_idx_q;
    assign bus_io.res_z    = res_z_q;
endmodule

// File: tb/tb_ddot_chunk_sched.sv
// Scoreboard bench for ddot_chunk_sched: buffer + fixed-latency basic_ddot model, directed jobs,
// and a monitor that checks results, addresses, ready timing and credit use.
module tb_ddot_chunk_sched;
    localparam int unsigned CntW   = 8;
    localparam int unsigned MaxOut = 4;
    localparam logic [255:0] XChunk = {8{32'h3f80_0000}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddot_chunk_sched_if #(.CNT_W(CntW)) bus ();

    ddot_chunk_sched #(.CNT_W(CntW), .MAX_OUT(MaxOut)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] z;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Chunk k: x lanes 1.0, y lanes 2^(k+1); eight lanes sum to 2^(k+4).
    function automatic logic [255:0] y_chunk(int k);
        logic [31:0] lane;
        lane = 32'(128 + k) << 23;
        return {8{lane}};
    endfunction

    function automatic logic [31:0] z_of(int k);
        return 32'(131 + k) << 23;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Buffer and basic_ddot model
    int   lat      = 3;
    logic spur_req = 1'b0;
    int   cyc_m    = 0;
    int   due_q[$];
    logic [31:0] zq[$];

    always @(posedge clk) begin
        cyc_m = cyc_m + 1;
        if (rst) begin
            due_q.delete();
            zq.delete();
            bus.dd_vld <= 1'b0;
            bus.dd_z   <= '0;
            bus.rd_x   <= '0;
            bus.rd_y   <= '0;
        end else begin
            if (bus.rd_en) begin
                bus.rd_x <= XChunk;
                bus.rd_y <= y_chunk(int'(bus.rd_addr));
            end
            if (bus.dd_ready) begin
                due_q.push_back(cyc_m + lat - 1);
                zq.push_back(bus.dd_y[31:0] + (32'd3 << 23));
            end
            if (due_q.size() > 0 && due_q[0] == cyc_m) begin
                bus.dd_vld <= 1'b1;
                bus.dd_z   <= zq.pop_front();
                void'(due_q.pop_front());
            end else if (spur_req) begin
                bus.dd_vld <= 1'b1;
                bus.dd_z   <= 32'hdead_beef;
            end else begin
                bus.dd_vld <= 1'b0;
            end
        end
    end

    // Monitor statistics
    int   cyc, n_rd, n_res, n_done, n_vld_seen, pre_rd, out_mon, max_out, exp_addr;
    int   run_rd, run_rdy, run_res, max_rd, max_rdy, max_res, t_resv, t_done;
    logic       prev_rd_en;
    logic [7:0] prev_rd_addr;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_rd_en = 1'b0;
                out_mon    = 0;
                run_rd     = 0;
                run_rdy    = 0;
                run_res    = 0;
            end else begin
                if (bus.res_vld) begin
                    n_res++;
                    t_resv = cyc;
                    if (exp_q.size() == 0) begin
                        chk("res_unexpected", 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_idx", 256'(bus.res_idx), 256'(e.idx));
                        chk("res_z", 256'(bus.res_z), 256'(e.z));
                    end
                end
                if (bus.dd_ready || prev_rd_en) begin
                    chk("ready_after_rd", 256'(bus.dd_ready), 256'(prev_rd_en));
                    if (bus.dd_ready) begin
                        chk("dd_x", bus.dd_x, XChunk);
                        chk("dd_y", bus.dd_y, y_chunk(int'(prev_rd_addr)));
                    end
                end
                if (bus.rd_en) begin
                    chk("rd_addr", 256'(bus.rd_addr), 256'(exp_addr));
                    exp_addr++;
                    n_rd++;
                    if (n_vld_seen == 0) pre_rd++;
                end
                if (bus.dd_vld && out_mon > 0) out_mon--;
                if (bus.rd_en) out_mon++;
                if (out_mon > max_out) max_out = out_mon;
                if (bus.dd_vld) n_vld_seen++;
                if (bus.done) begin
                    n_done++;
                    t_done = cyc;
                end
                run_rd  = bus.rd_en    ? run_rd + 1  : 0;
                run_rdy = bus.dd_ready ? run_rdy + 1 : 0;
                run_res = bus.res_vld  ? run_res + 1 : 0;
                if (run_rd > max_rd) max_rd = run_rd;
                if (run_rdy > max_rdy) max_rdy = run_rdy;
                if (run_res > max_res) max_res = run_res;
                prev_rd_en   = bus.rd_en;
                prev_rd_addr = bus.rd_addr;
            end
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_res = 0; n_done = 0; n_vld_seen = 0; pre_rd = 0; max_out = 0;
        exp_addr = 0; max_rd = 0; max_rdy = 0; max_res = 0; t_resv = 0; t_done = 0;
    endtask

    task automatic start_job(input int n, input bool_push = 1);
        clear_stats();
        if (bool_push != 0) begin
            for (int k = 0; k < n; k++) exp_q.push_back('{idx: 8'(k), z: z_of(k)});
        end
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.num_chunks = 8'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk("done_seen", 256'(bus.done), 256'(1));
        chk("busy_at_done", 256'(bus.busy), 256'(1));
        @(negedge clk);
        chk("busy_after_done", 256'(bus.busy), 256'(0));
        chk("done_one_cycle", 256'(bus.done), 256'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_done", 256'(bus.done), 256'(0));
        chk("rst_err", 256'(bus.err), 256'(0));
        chk("rst_rd_en", 256'(bus.rd_en), 256'(0));
        chk("rst_rd_addr", 256'(bus.rd_addr), 256'(0));
        chk("rst_dd_ready", 256'(bus.dd_ready), 256'(0));
        chk("rst_res_vld", 256'(bus.res_vld), 256'(0));
        chk("rst_res_idx", 256'(bus.res_idx), 256'(0));
        chk("rst_res_z", 256'(bus.res_z), 256'(0));
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.num_chunks = '0;
        cyc            = 0;
        out_mon        = 0;
        run_rd         = 0;
        run_rdy        = 0;
        run_res        = 0;
        prev_rd_en     = 1'b0;
        prev_rd_addr   = '0;
        clear_stats();
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();

        // Basic chunk, latency 3
        lat = 3;
        start_job(1);
        wait_done(50);
        chk("basic_n_rd", 256'(n_rd), 256'(1));
        chk("basic_n_res", 256'(n_res), 256'(1));
        chk("basic_done_lag", 256'(t_done - t_resv), 256'(1));
        chk("basic_n_done", 256'(n_done), 256'(1));
        chk("basic_err", 256'(bus.err), 256'(0));

        // Credit limit, latency 8
        lat = 8;
        start_job(10);
        wait_done(300);
        chk("credit_pre_rd", 256'(pre_rd), 256'(4));
        chk("credit_max_out", 256'(max_out), 256'(4));
        chk("credit_n_res", 256'(n_res), 256'(10));
        chk("credit_n_done", 256'(n_done), 256'(1));
        chk("credit_q_empty", 256'(exp_q.size()), 256'(0));

        // Full throughput, latency 1
        lat = 1;
        start_job(6);
        wait_done(100);
        chk("thru_rd_run", 256'(max_rd), 256'(6));
        chk("thru_rdy_run", 256'(max_rdy), 256'(6));
        chk("thru_res_run", 256'(max_res), 256'(6));
        chk("thru_n_rd", 256'(n_rd), 256'(6));

        // Empty job
        start_job(0);
        @(negedge clk);
        chk("empty_done", 256'(bus.done), 256'(1));
        chk("empty_busy", 256'(bus.busy), 256'(1));
        @(negedge clk);
        chk("empty_busy_low", 256'(bus.busy), 256'(0));
        chk("empty_done_low", 256'(bus.done), 256'(0));
        chk("empty_n_rd", 256'(n_rd), 256'(0));

        // Reset mid-job, then a fresh two-chunk job
        lat = 3;
        start_job(8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n_rd >= 3) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        chk("abort_no_done", 256'(n_done), 256'(0));
        repeat (2) @(negedge clk);
        start_job(2);
        wait_done(50);
        chk("after_rst_n_rd", 256'(n_rd), 256'(2));
        chk("after_rst_n_res", 256'(n_res), 256'(2));
        chk("after_rst_q_empty", 256'(exp_q.size()), 256'(0));

        // Spurious result in IDLE, then a start ignored during ISSUE
        clear_stats();
        @(posedge clk);
        #1;
        spur_req = 1'b1;
        @(posedge clk);
        #1;
        spur_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_err", 256'(bus.err), 256'(1));
        chk("spur_no_res", 256'(n_res), 256'(0));
        lat = 8;
        start_job(3);
        @(negedge clk);
        chk("err_cleared", 256'(bus.err), 256'(0));
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.num_chunks = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(200);
        chk("ign_n_rd", 256'(n_rd), 256'(3));
        chk("ign_n_res", 256'(n_res), 256'(3));
        chk("ign_n_done", 256'(n_done), 256'(1));
        chk("ign_q_empty", 256'(exp_q.size()), 256'(0));
        chk("ign_err", 256'(bus.err), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddot_chunk_sched.md
Name: ddot_chunk_sched

Overview:
- Scheduler that sequences the 8-lane fp32 dot-product datapath (basic_ddot) over a long vector held in a synchronous dual-operand buffer.
- Each 8-element chunk is fetched from the buffer and issued to basic_ddot with a single-cycle ready pulse.
- Each chunk's partial result (z on vld) is returned tagged with its chunk index.
- Sits between a host/command block (start, num_chunks) and the buffer + basic_ddot pair. Performs no FP arithmetic; the result latency of basic_ddot is handled by credit counting.

Parameters:
- CNT_W, 8, width of chunk count, chunk address and result index.
- MAX_OUT, 4, max chunks in flight (issued reads not yet answered by dd_vld); range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- num_chunks  in  CNT_W  chunks in job; sampled with start.
- busy  out  1  high from accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last result has been returned.
- err  out  1  sticky; set on dd_vld with no chunk outstanding; cleared by rst or accepted start.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  CNT_W  chunk address; valid with rd_en.
- rd_x  in  256  x lanes 0..7 (lane i = bits 32i+31:32i); valid the cycle after rd_en.
- rd_y  in  256  y lanes, same packing and timing as rd_x.
- dd_ready  out  1  issue pulse to basic_ddot.
- dd_x  out  256  combinational pass-through of rd_x.
- dd_y  out  256  combinational pass-through of rd_y.
- dd_vld  in  1  basic_ddot result valid; in-order; any latency ≥1.
- dd_z  in  32  basic_ddot result.
- res_vld  out  1  registered copy of dd_vld while a chunk is outstanding; no backpressure.
- res_idx  out  CNT_W  chunk index of res_z.
- res_z  out  32  registered dd_z.

Behaviour:
- Reset values: busy=0, done=0, err=0, rd_en=0, rd_addr=0, dd_ready=0, res_vld=0, res_idx=0, res_z=0. All counters are cleared and the FSM enters IDLE. Reset mid-job abandons the job with no done pulse.
- Counters:
  - iss: reads issued.
  - col: results collected.
  - out: in-flight count, CNT_W+1 bits wide.
  - out is incremented on rd_en and decremented on dd_vld. When both occur in the same cycle, out is unchanged.
- IDLE:
  - start=1 with num_chunks>0 latches N, clears iss/col/out/err, and goes to ISSUE.
  - start=1 with num_chunks=0 goes to FIN with no reads issued.
- ISSUE:
  - rd_en=1 and rd_addr=iss (registered) when iss<N and out<MAX_OUT. Otherwise rd_en=0.
  - The out<MAX_OUT check uses the pre-update value of out; a dd_vld in the same cycle does not enable an extra read.
  - Transitions to DRAIN in the cycle after iss reaches N.
- dd_ready: rd_en delayed by one register stage. dd_x/dd_y are therefore valid exactly while dd_ready=1. Back-to-back reads produce back-to-back ready pulses.
- Result collection (ISSUE or DRAIN, out>0 or rd_en in the prior cycle):
  - dd_vld registers res_vld=1, res_z=dd_z and res_idx=col, then increments col.
  - Latency from dd_vld to res_vld is 1 cycle.
- DRAIN: goes to FIN on the cycle col reaches N.
- FIN: done=1 and busy=1 for one cycle, then IDLE. busy drops in the cycle after done.
- Idle results: dd_vld while out=0 (IDLE, FIN, or a spurious pulse) does not assert res_vld, sets err, and leaves col unchanged.
- start outside IDLE is ignored.
- num_chunks=2^CNT_W-1 is the maximum job. rd_addr runs 0..N-1 and never wraps within a job.

Test Plan:
- Basic chunk: buffer chunk 0 = x all 0x3f800000, y all 0x40000000; basic_ddot model latency 3; start, N=1.
  - Response: one rd_en at addr 0; dd_ready 1 cycle later; res_vld with res_idx=0, res_z=0x41800000; done 1 cycle after res_vld; busy low the next cycle.
- Credit limit: N=10, MAX_OUT=4, model latency 8.
  - Response: at most 4 reads before the first dd_vld; out never exceeds 4; res_idx 0..9 in order; exactly 10 res_vld; one done.
- Full throughput: N=6, model latency 1.
  - Response: rd_en high 6 consecutive cycles (addr 0..5); dd_ready high 6 consecutive cycles; res_vld high 6 consecutive cycles.
- Empty job: start with N=0.
  - Response: no rd_en; done and busy high in the cycle after start; busy low the following cycle.
- Reset mid-job: N=8; assert rst after 3 issues for 1 cycle; then start N=2.
  - Response: all outputs return to reset values the cycle after rst; no done for the first job; the second job reads addr 0,1 and returns res_idx 0,1 then done.
- Spurious result and ignored start: pulse dd_vld in IDLE, then start during ISSUE.
  - Response: err=1 with no res_vld; the second start has no effect on N or addresses; err clears on the next accepted start.
